regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file of the CPU core: 32 x 32-bit MIPS integer registers.
- Responds to the operand read requests issued by the decode stage (two read ports).
- Accepts one result write per cycle from the write-back stage.
- Provides write-to-read forwarding so decode sees the value being written back in the same cycle; register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register (matches `RegBus).
- ADDR_W, 5, register address width (matches `RegAddrBus).
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W (matches `RegNum).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high (`RstEnable = 1'b1).
- we  input  1  write enable from write-back (`WriteEnable = 1'b1).
- waddr  input  ADDR_W  destination register address.
- wdata  input  DATA_W  write data.
- re1  input  1  read enable, port 1 (decode reg1_read).
- raddr1  input  ADDR_W  read address, port 1 (decode reg1_addr).
- rdata1  output  DATA_W  read data, port 1 (to decode reg1_data).
- re2  input  1  read enable, port 2 (decode reg2_read).
- raddr2  input  ADDR_W  read address, port 2 (decode reg2_addr).
- rdata2  output  DATA_W  read data, port 2 (to decode reg2_data).

Behaviour:
- Storage: array regs[0..NUM_REGS-1], each DATA_W bits.
- Reset:
  - At a rising edge with rst=1, all registers clear to `ZeroWord.
  - A write presented in the same cycle is discarded.
  - While rst=1, rdata1 and rdata2 are combinationally `ZeroWord, regardless of re/we.
- Write, at a rising edge with rst=0 and we=1:
  - If waddr!=0, regs[waddr] <= wdata.
  - waddr=0 is ignored; regs[0] always reads 0.
  - Write latency is 1 cycle: data is visible in the array from the next cycle.
- Read, combinational, zero latency, evaluated independently per port n in {1,2}, first matching rule wins:
  1. rst=1 -> 0.
  2. raddrn=0 -> 0, even if re=1 and a write to 0 is pending.
  3. ren=1 and we=1 and waddr==raddrn -> wdata (forwarding).
  4. ren=1 -> regs[raddrn].
  5. ren=0 -> 0.
- Simultaneous events:
  - Both ports may read the same address; both return identical data, including forwarded data.
  - Both ports may hit the forward path in the same cycle.
  - A read and a write to the same non-zero address in one cycle returns the new data combinationally; the array holds the new data from the next cycle.
- Reset mid-operation: rst asserted for one cycle clears every register. After rst deasserts, the first write takes effect at the next edge.
- No X propagation: outputs are fully defined for any input combination; there are no latches.
- Width rules:
  - No arithmetic is performed.
  - Addresses are compared over the full ADDR_W bits.
  - Data passes unmodified.

Decomposition:
- Shared defines header (already existing): RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, RstEnable, WriteEnable, ReadEnable, NOPRegAddr. No new constants are added.
- Sub-module: regfile_rport, one combinational read port implementing read rules 1-5. Instantiate it twice to keep the forwarding logic identical across both ports.
- Array and write logic live in the top module.

Test Plan:
- Reset clear: write 0xDEADBEEF to $5, then hold rst=1 for one edge. Afterwards, re1=1/raddr1=5 returns 0x00000000.
- Basic write/read: we=1, waddr=8, wdata=0x12345678, then deassert we. Next cycle, re1=1/raddr1=8 and re2=1/raddr2=8 both return 0x12345678.
- Forwarding: regs[3]=0x11111111. In one cycle drive we=1, waddr=3, wdata=0x22222222 with re2=1, raddr2=3. rdata2=0x22222222 combinationally in that cycle; the next cycle, without writing, it reads 0x22222222.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF with re1=1/raddr1=0 in the same cycle. rdata1=0 in that cycle and in every later cycle.
- Read disable: regs[7]=0xA5A5A5A5, re1=0, raddr1=7, including the case we=1/waddr=7. rdata1=0x00000000.
- Reset vs write collision: rst=1 and we=1, waddr=9, wdata=0x0BADF00D in the same cycle. After rst drops, raddr1=9 with re1=1 returns 0x00000000.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types; mirrors the core's existing defines.
package regfile_pkg;

  localparam int DATA_W   = 32;               // RegBus
  localparam int ADDR_W   = 5;                // RegAddrBus
  localparam int NUM_REGS = 32;               // RegNum
  localparam int NUM_REGS_LOG2 = ADDR_W;      // RegNumLog2

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam word_t ZERO_WORD    = '0;        // ZeroWord
  localparam logic  RST_ENABLE   = 1'b1;      // RstEnable
  localparam logic  WRITE_ENABLE = 1'b1;      // WriteEnable
  localparam logic  READ_ENABLE  = 1'b1;      // ReadEnable
  localparam addr_t NOP_REG_ADDR = '0;        // NOPRegAddr

endpackage

// File: rtl/regfile_if.sv
// Write-back write port plus the two decode read ports of the register file.
interface regfile_if;
  import regfile_pkg::*;

  logic  we;
  addr_t waddr;
  word_t wdata;
  logic  re1;
  addr_t raddr1;
  word_t rdata1;
  logic  re2;
  addr_t raddr2;
  word_t rdata2;

  // Pipeline side: write-back drives the write, decode drives reads.
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  // Register-file side.
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_rport.sv
// One combinational read port: reset, $zero, write forwarding, array, disable.
module regfile_rport
  import regfile_pkg::*;
(
  input  logic  rst,
  input  logic  re,
  input  addr_t raddr,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  word_t arr_val,   // regs[raddr] as currently stored
  output word_t rdata
);

  // Priority chain; $zero wins over forwarding so a pending write to 0 never leaks.
  always_comb begin
    rdata = ZERO_WORD;
    if (rst == RST_ENABLE)                   rdata = ZERO_WORD;
    else if (raddr == NOP_REG_ADDR)          rdata = ZERO_WORD;
    else if (re == READ_ENABLE && we == WRITE_ENABLE && waddr == raddr)
                                             rdata = wdata;
    else if (re == READ_ENABLE)              rdata = arr_val;
    else                                     rdata = ZERO_WORD;
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32 MIPS integer register file: one write, two forwarded reads.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  // Next array state: single write-back update; writes to $zero are dropped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (bus.we == WRITE_ENABLE && bus.waddr != NOP_REG_ADDR)
      regs_d[bus.waddr] = bus.wdata;
  end

  // Array register; synchronous reset clears all and swallows a colliding write.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= ZERO_WORD;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Both ports share one implementation so forwarding behaves identically.
  regfile_rport u_rport1 (
    .rst     (rst),
    .re      (bus.re1),
    .raddr   (bus.raddr1),
    .we      (bus.we),
    .waddr   (bus.waddr),
    .wdata   (bus.wdata),
    .arr_val (regs_q[bus.raddr1]),
    .rdata   (bus.rdata1)
  );

  regfile_rport u_rport2 (
    .rst     (rst),
    .re      (bus.re2),
    .raddr   (bus.raddr2),
    .we      (bus.we),
    .waddr   (bus.waddr),
    .wdata   (bus.wdata),
    .arr_val (regs_q[bus.raddr2]),
    .rdata   (bus.rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: hand-computed vectors, immediate-assert checks.
module tb_regfile;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_if bus ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0;
    bus.re2 = 1'b0; bus.raddr2 = '0;
  endtask

  task automatic wr(input addr_t a, input word_t d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();

    // Reset: outputs zero regardless of enables, even with a write forwarded.
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hCAFEF00D;
    #1;
    chk("rst_rd1", bus.rdata1, 32'h0);
    chk("rst_rd2", bus.rdata2, 32'h0);
    step();
    idle();
    rst = 1'b0;
    #1;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    chk("rst_drop_wr_discard", bus.rdata1, 32'h0);

    // Reset clear of a written register (also clears others, e.g. $8).
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd8, 32'h01020304);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    #1;
    chk("pre_rst_r5", bus.rdata1, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_r5", bus.rdata1, 32'h0);
    bus.raddr1 = 5'd8;
    #1;
    chk("post_rst_r8", bus.rdata1, 32'h0);

    // Basic write then dual read of the same address.
    idle();
    wr(5'd8, 32'h12345678);
    bus.re1 = 1'b1; bus.raddr1 = 5'd8;
    bus.re2 = 1'b1; bus.raddr2 = 5'd8;
    #1;
    chk("basic_rd1", bus.rdata1, 32'h12345678);
    chk("basic_rd2", bus.rdata2, 32'h12345678);

    // Forwarding on both ports; array holds new value next cycle.
    idle();
    wr(5'd3, 32'h11111111);
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    bus.re2 = 1'b1; bus.raddr2 = 5'd3;
    #1;
    chk("fwd_old", bus.rdata2, 32'h11111111);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h22222222;
    #1;
    chk("fwd_rd2", bus.rdata2, 32'h22222222);
    chk("fwd_rd1", bus.rdata1, 32'h22222222);
    step();
    bus.we = 1'b0;
    #1;
    chk("fwd_stored", bus.rdata2, 32'h22222222);

    // Write to a different address with matching low bits: no forwarding.
    bus.we = 1'b1; bus.waddr = 5'd19; bus.wdata = 32'h33333333;
    #1;
    chk("fwd_addr_fullwidth", bus.rdata2, 32'h22222222);
    step();
    bus.we = 1'b0;
    bus.raddr1 = 5'd19;
    #1;
    chk("r19_stored", bus.rdata1, 32'h33333333);

    // $zero: pending write never forwarded, never stored.
    idle();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    #1;
    chk("zero_same_cycle", bus.rdata1, 32'h0);
    step();
    bus.we = 1'b0;
    #1;
    chk("zero_later", bus.rdata1, 32'h0);

    // Read disable, with and without a matching write.
    idle();
    wr(5'd7, 32'hA5A5A5A5);
    bus.re1 = 1'b0; bus.raddr1 = 5'd7;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    #1;
    chk("rdis_plain", bus.rdata1, 32'h0);
    chk("ren_plain", bus.rdata2, 32'hA5A5A5A5);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h5A5A5A5A;
    #1;
    chk("rdis_with_wr", bus.rdata1, 32'h0);
    chk("ren_with_wr_fwd", bus.rdata2, 32'h5A5A5A5A);
    step();
    bus.we = 1'b0;

    // Reset/write collision: write discarded; first write after reset lands.
    idle();
    rst = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h0BADF00D;
    step();
    rst = 1'b0;
    bus.we = 1'b0;
    bus.re1 = 1'b1; bus.raddr1 = 5'd9;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    #1;
    chk("rst_coll_r9", bus.rdata1, 32'h0);
    chk("rst_coll_r7", bus.rdata2, 32'h0);
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h600DF00D;
    step();
    bus.we = 1'b0;
    #1;
    chk("post_rst_first_wr", bus.rdata1, 32'h600DF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
